// File: rtl/instr_enc_pkg.sv
// Shared constants for the RV32I field encoder/loader: class codes, opcodes,
// funct3 values, error codes and the loader state type.
package instr_enc_pkg;

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_OPIMM  = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_RTYPE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SRX = 3'b101;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENC,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } ld_state_e;

  // True when the 21-bit immediate is representable as a 12-bit signed value.
  function automatic logic fits_s12(input logic [20:0] imm);
    return (&imm[20:11]) || !(|imm[20:11]);
  endfunction

  function automatic logic fits_s13(input logic [20:0] imm);
    return (&imm[20:12]) || !(|imm[20:12]);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I packer: builds the instruction word from fields and
// reports legality (illegal encoding beats immediate range/alignment).
module instr_field_packer
  import instr_enc_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  f3,
  input  logic        f7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        ok,
  output logic [1:0]  code
);

  logic illegal;
  logic range_bad;

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_bad = 1'b0;
    case (cls)
      CLS_LOAD: begin
        word      = {imm[11:0], rs1, f3, rd, OP_LOAD};
        illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        range_bad = !fits_s12(imm);
      end
      CLS_OPIMM: begin
        illegal = f7b5 && (f3 != F3_SRX);
        if (f3 == F3_SLL || f3 == F3_SRX) begin
          word      = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, OP_OPIMM};
          range_bad = |imm[20:5];
        end else begin
          word      = {imm[11:0], rs1, f3, rd, OP_OPIMM};
          range_bad = !fits_s12(imm);
        end
      end
      CLS_STORE: begin
        word      = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
        illegal   = (f3 != F3_SW);
        range_bad = !fits_s12(imm);
      end
      CLS_RTYPE: begin
        word    = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OP_RTYPE};
        illegal = f7b5 && !(f3 == F3_ADD || f3 == F3_SRX);
      end
      CLS_BRANCH: begin
        word      = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        illegal   = (f3 != F3_BEQ);
        range_bad = imm[0] || !fits_s13(imm);
      end
      CLS_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        range_bad = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ok   = !illegal && !range_bad;
  assign code = illegal ? ERR_ILLEGAL : (range_bad ? ERR_RANGE : ERR_NONE);

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts field bundles over valid/ready, encodes them to RV32I words and
// writes them to instruction memory at sequential word addresses.
module instr_encode_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned  DEPTH     = 256,
  parameter logic [31:0]  BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_class,
  input  logic [2:0]             in_funct3,
  input  logic                   in_f7b5,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [20:0]            in_imm,
  input  logic                   in_last,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   load_done,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ld_state_e state, state_n;

  logic [2:0]  cls_q, f3_q;
  logic        f7b5_q, last_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [20:0] imm_q;

  logic [31:0]   pk_word;
  logic          pk_ok;
  logic [1:0]    pk_code;
  logic          set_err;
  logic [1:0]    code_n;
  logic [CW-1:0] cnt_inc;

  instr_field_packer u_packer (
    .cls  (cls_q),
    .f3   (f3_q),
    .f7b5 (f7b5_q),
    .rd   (rd_q),
    .rs1  (rs1_q),
    .rs2  (rs2_q),
    .imm  (imm_q),
    .word (pk_word),
    .ok   (pk_ok),
    .code (pk_code)
  );

  assign cnt_inc = count + 1'b1;

  always_comb begin
    state_n = state;
    set_err = 1'b0;
    code_n  = ERR_NONE;
    case (state)
      ST_IDLE:  if (in_valid) state_n = ST_ENC;
      ST_ENC: begin
        if (pk_ok) begin
          state_n = ST_WRITE;
        end else begin
          state_n = ST_ERR;
          set_err = 1'b1;
          code_n  = pk_code;
        end
      end
      ST_WRITE: begin
        if (last_q) begin
          state_n = ST_DONE;
        end else if (cnt_inc == CW'(DEPTH)) begin
          state_n = ST_DONE;
          set_err = 1'b1;
          code_n  = ERR_OVERFLOW;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DONE:  state_n = ST_DONE;
      ST_ERR:   state_n = ST_ERR;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (clr) begin
      state    <= ST_IDLE;
      count    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state <= state_n;
      if (state == ST_WRITE) count <= cnt_inc;
      if (set_err) begin
        err      <= 1'b1;
        err_code <= code_n;
      end
    end
  end

  // Fields stay frozen from accept until the word is written, so the packer
  // output can feed mem_wdata directly during WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q  <= '0;
      f3_q   <= '0;
      f7b5_q <= 1'b0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      last_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      cls_q  <= in_class;
      f3_q   <= in_funct3;
      f7b5_q <= in_f7b5;
      rd_q   <= in_rd;
      rs1_q  <= in_rs1;
      rs2_q  <= in_rs2;
      imm_q  <= in_imm;
      last_q <= in_last;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign load_done = (state == ST_DONE);
  assign mem_we    = (state == ST_WRITE) && !clr;
  assign mem_addr  = (state == ST_WRITE) ?
                     BASE_ADDR + {{(32-CW-2){1'b0}}, count, 2'b00} : '0;
  assign mem_wdata = (state == ST_WRITE) ? pk_word : '0;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader (DEPTH=4): expected writes are
// queued at stimulus time and matched against every mem_we strobe.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_class = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_f7b5 = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [20:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  count;
  logic        load_done, err;
  logic [1:0]  err_code;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  instr_encode_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .load_done(load_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h expected=no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== {e.addr, e.data}) begin
          failures++;
          $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [20:0] imm, input logic last);
    int unsigned t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout in_ready=%b expected=1", in_ready);
    end
    in_class = c; in_funct3 = f3; in_f7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata, count, load_done, err, err_code} !== '0) begin
      failures++;
      $display("FAIL reset_outputs we=%b addr=%h data=%h count=%0d done=%b err=%b code=%b expected all 0",
               mem_we, mem_addr, mem_wdata, count, load_done, err, err_code);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready in_ready=%b expected=1", in_ready);
    end
  endtask

  task automatic test_addi();
    expect_write(32'h0, 32'h00500093);
    send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL addi_latency_enc mem_we=%b expected=0", mem_we);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin
      failures++;
      $display("FAIL addi_latency_write mem_we=%b expected=1", mem_we);
    end
    drain();
    checks++;
    if ({count, in_ready, load_done, mem_addr, mem_wdata} !== {3'd1, 1'b1, 1'b0, 64'h0}) begin
      failures++;
      $display("FAIL addi_after count=%0d ready=%b done=%b addr=%h data=%h expected 1 1 0 0 0",
               count, in_ready, load_done, mem_addr, mem_wdata);
    end
    do_clr();
  endtask

  task automatic test_load_store();
    expect_write(32'h0, 32'h0080A103);
    expect_write(32'h4, 32'h00202623);
    send(3'd0, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, 21'd8, 1'b0);
    send(3'd2, 3'b010, 1'b0, 5'd0, 5'd0, 5'd2, 21'd12, 1'b1);
    drain();
    checks++;
    if ({load_done, count, in_ready, err} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_store_done done=%b count=%0d ready=%b err=%b expected 1 2 0 0",
               load_done, count, in_ready, err);
    end
    do_clr();
  endtask

  // Four words with in_last on the fourth: reaches DEPTH without error.
  task automatic test_branch_jal();
    expect_write(32'h0, 32'hFE208CE3);
    expect_write(32'h4, 32'h40725193);
    expect_write(32'h8, 32'h407302B3);
    expect_write(32'hC, 32'h0000006F);
    send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFF8, 1'b0);
    send(3'd1, 3'b101, 1'b1, 5'd3, 5'd4, 5'd0, 21'd7, 1'b0);
    send(3'd3, 3'b000, 1'b1, 5'd5, 5'd6, 5'd7, 21'd0, 1'b0);
    send(3'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 21'd0, 1'b1);
    drain();
    checks++;
    if ({load_done, count, err, err_code} !== {1'b1, 3'd4, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL last_at_depth done=%b count=%0d err=%b code=%b expected 1 4 0 00",
               load_done, count, err, err_code);
    end
    do_clr();
  endtask

  task automatic check_err(input logic [1:0] exp_code, input string name);
    repeat (3) @(negedge clk);
    checks++;
    if ({err, err_code, in_ready, load_done, count} !== {1'b1, exp_code, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL %s err=%b code=%b ready=%b done=%b count=%0d expected 1 %b 0 0 0",
               name, err, err_code, in_ready, load_done, count, exp_code);
    end
    do_clr();
    checks++;
    if ({in_ready, err, err_code, count} !== {1'b1, 1'b0, 2'b00, 3'd0}) begin
      failures++;
      $display("FAIL %s_clr ready=%b err=%b code=%b count=%0d expected 1 0 00 0",
               name, in_ready, err, err_code, count);
    end
  endtask

  task automatic test_errors();
    send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'd3, 1'b0);
    check_err(2'b10, "branch_odd");
    send(3'd0, 3'b011, 1'b0, 5'd1, 5'd1, 5'd0, 21'd4, 1'b0);
    check_err(2'b01, "load_f3");
    send(3'd0, 3'b011, 1'b0, 5'd1, 5'd1, 5'd0, 21'd5000, 1'b0);
    check_err(2'b01, "priority");
    send(3'd1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 21'd32, 1'b0);
    check_err(2'b10, "shamt_range");
    send(3'd6, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 21'd0, 1'b0);
    check_err(2'b01, "bad_class");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      expect_write(32'(i * 4), 32'h00100093 + 32'(i << 7));
      send(3'd1, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 21'd1, 1'b0);
    end
    drain();
    checks++;
    if ({load_done, err, err_code, count} !== {1'b1, 1'b1, 2'b11, 3'd4}) begin
      failures++;
      $display("FAIL overflow done=%b err=%b code=%b count=%0d expected 1 1 11 4",
               load_done, err, err_code, count);
    end
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({in_ready, count, load_done} !== {1'b0, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL overflow_reject ready=%b count=%0d done=%b expected 0 4 1",
               in_ready, count, load_done);
    end
    in_valid = 1'b0;
    do_clr();
  endtask

  task automatic test_clr_in_write();
    send(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd16, 1'b0);
    @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL clr_write_suppress mem_we=%b expected=0", mem_we);
    end
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if ({in_ready, count} !== {1'b1, 3'd0}) begin
      failures++;
      $display("FAIL clr_write_state ready=%b count=%0d expected 1 0", in_ready, count);
    end
  endtask

  task automatic test_rst_mid_write();
    expect_write(32'h0, 32'h00500093);
    send(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0);
    send(3'd1, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 21'd6, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if ({mem_we, mem_addr, count} !== {1'b1, 32'h4, 3'd1}) begin
      failures++;
      $display("FAIL pre_rst we=%b addr=%h count=%0d expected 1 00000004 1", mem_we, mem_addr, count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_we, count} !== {1'b0, 3'd0}) begin
      failures++;
      $display("FAIL rst_mid_write we=%b count=%0d expected 0 0", mem_we, count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_write(32'h0, 32'h00700193);
    send(3'd1, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 21'd7, 1'b1);
    drain();
    checks++;
    if ({load_done, count, err} !== {1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL restart done=%b count=%0d err=%b expected 1 1 0", load_done, count, err);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_store();
    test_branch_jal();
    test_errors();
    test_overflow();
    test_clr_in_write();
    test_rst_mid_write();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
